// File: rtl/spike_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// spike_pattern_sequencer
//
// Batch-writable spike pattern store with a playback engine. The host loads
// timesteps of NUM_SPIKES-wide spike vectors one SPIKES_PER_BATCH-wide slice
// at a time. On start the engine replays timesteps 0..last_timestep over a
// valid/ready stream, optionally looping, and can be aborted with stop.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   mem_addr        host timestep address (write and read)
//   batch_sel       host batch select within the timestep vector
//   mem_wen         host write enable (only honoured while idle)
//   mem_data_in     host write data
//   mem_data_out    host read data, one cycle after mem_addr/batch_sel
//   start, stop     playback start / abort pulses
//   loop_en         wrap back to timestep 0 after last_timestep
//   last_timestep   final timestep index, sampled at start
//   spikes          presented spike vector (0 when spikes_valid is low)
//   spikes_valid    spikes holds a timestep vector
//   spikes_ready    consumer accepts the presented vector
//   timestep        index of the presented vector
//   busy            playback active
//   done            one-cycle pulse on normal completion
//   wr_drop         one-cycle pulse: previous host write was ignored
// ---------------------------------------------------------------------------
module spike_pattern_sequencer #(
  parameter int NUM_SPIKES                     = 100,
  parameter int TIMESTEP_ADDR_WIDTH            = 8,
  parameter int SPIKES_PER_BATCH               = 32,
  parameter int SPIKE_PATTERN_BATCH_ADDR_WIDTH = 6
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [TIMESTEP_ADDR_WIDTH-1:0]            mem_addr,
  input  logic [SPIKE_PATTERN_BATCH_ADDR_WIDTH-1:0] batch_sel,
  input  logic                                      mem_wen,
  input  logic [SPIKES_PER_BATCH-1:0]               mem_data_in,
  output logic [SPIKES_PER_BATCH-1:0]               mem_data_out,
  input  logic                                      start,
  input  logic                                      stop,
  input  logic                                      loop_en,
  input  logic [TIMESTEP_ADDR_WIDTH-1:0]            last_timestep,
  output logic [NUM_SPIKES-1:0]                     spikes,
  output logic                                      spikes_valid,
  input  logic                                      spikes_ready,
  output logic [TIMESTEP_ADDR_WIDTH-1:0]            timestep,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      wr_drop
);

  localparam int TAW         = TIMESTEP_ADDR_WIDTH;
  localparam int BAW         = SPIKE_PATTERN_BATCH_ADDR_WIDTH;
  localparam int SPB         = SPIKES_PER_BATCH;
  localparam int NUM_BATCHES = (NUM_SPIKES + SPB - 1) / SPB;
  localparam int DEPTH       = 2 ** TAW;

  // One extra bit so the comparison cannot overflow when NUM_BATCHES == 2**BAW.
  localparam logic [BAW:0] NUM_BATCHES_W = (BAW + 1)'(NUM_BATCHES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]     state_reg;
  logic [TAW-1:0] counter_reg;
  logic [TAW-1:0] last_reg;
  logic           loop_reg;
  logic           busy_reg;
  logic           done_reg;
  logic           valid_reg;
  logic [TAW-1:0] timestep_reg;
  logic           wr_drop_reg;
  logic [BAW-1:0] host_sel_reg;
  logic           host_sel_valid_reg;

  logic           batch_ok;
  logic           wr_en;
  logic           handshake;

  logic [SPB-1:0]        host_rd_word [NUM_BATCHES];
  logic [NUM_SPIKES-1:0] play_vec;

  assign batch_ok  = ({1'b0, batch_sel} < NUM_BATCHES_W);
  assign wr_en     = mem_wen && batch_ok && (state_reg == S_IDLE) && !busy_reg;
  assign handshake = valid_reg && spikes_ready;

  // -------------------------------------------------------------------------
  // Pattern memory: one RAM per batch. Only the bits that map onto real
  // neurons are stored, so padding bits of the last batch are discarded on
  // write and read back as zero without any masking logic.
  // Port A: host read/write at mem_addr. Port B: playback read at counter_reg.
  // Registered reads give old data on a same-address read-during-write.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_BATCHES; gi++) begin : g_batch
      localparam int LO = gi * SPB;
      localparam int VB = ((NUM_SPIKES - LO) >= SPB) ? SPB : (NUM_SPIKES - LO);

      logic [VB-1:0] mem [DEPTH];
      logic [VB-1:0] host_rd_reg;
      logic [VB-1:0] play_rd_reg;
      logic          sel_hit;

      assign sel_hit = (batch_sel == BAW'(gi));

      always_ff @(posedge clk) begin
        if (wr_en && sel_hit) begin
          mem[mem_addr] <= mem_data_in[VB-1:0];
        end
        host_rd_reg <= mem[mem_addr];
        play_rd_reg <= mem[counter_reg];
      end

      assign host_rd_word[gi]   = SPB'(host_rd_reg);
      assign play_vec[LO +: VB] = play_rd_reg;
    end
  endgenerate

  // Host read mux. The batch select is registered alongside the RAM read so
  // the one-cycle latency lines up; an out-of-range select reads zero.
  always_comb begin
    mem_data_out = '0;
    if (host_sel_valid_reg) begin
      for (int i = 0; i < NUM_BATCHES; i++) begin
        if (host_sel_reg == BAW'(i)) begin
          mem_data_out = host_rd_word[i];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Playback FSM. FETCH spends one cycle while the playback RAM port reads
  // entry counter_reg; the RAM output register then drives spikes directly
  // for the whole PRESENT phase (the address and memory cannot change while
  // busy, so the read stays stable under back-pressure).
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= S_IDLE;
      counter_reg        <= '0;
      last_reg           <= '0;
      loop_reg           <= 1'b0;
      busy_reg           <= 1'b0;
      done_reg           <= 1'b0;
      valid_reg          <= 1'b0;
      timestep_reg       <= '0;
      wr_drop_reg        <= 1'b0;
      host_sel_reg       <= '0;
      host_sel_valid_reg <= 1'b0;
    end else begin
      done_reg           <= 1'b0;
      wr_drop_reg        <= mem_wen && !wr_en;
      host_sel_reg       <= batch_sel;
      host_sel_valid_reg <= batch_ok;

      case (state_reg)
        S_IDLE: begin
          // start together with stop is treated as no request at all.
          if (start && !stop) begin
            loop_reg    <= loop_en;
            last_reg    <= last_timestep;
            counter_reg <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (stop) begin
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            valid_reg    <= 1'b1;
            timestep_reg <= counter_reg;
            state_reg    <= S_PRESENT;
          end
        end

        S_PRESENT: begin
          if (stop) begin
            // A transfer coinciding with stop has already happened on this
            // edge; the abort simply suppresses the next step and done.
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            state_reg <= S_IDLE;
          end else if (handshake) begin
            valid_reg <= 1'b0;
            if (counter_reg < last_reg) begin
              counter_reg <= counter_reg + 1'b1;
              state_reg   <= S_FETCH;
            end else if (loop_reg) begin
              counter_reg <= '0;
              state_reg   <= S_FETCH;
            end else begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= S_DONE;
            end
          end
        end

        default: begin
          // S_DONE: done is high for exactly this cycle.
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // spikes reads as zero whenever nothing is being presented, which also
  // covers the cycle after each handshake and the reset state.
  assign spikes       = valid_reg ? play_vec : '0;
  assign spikes_valid = valid_reg;
  assign timestep     = timestep_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign wr_drop      = wr_drop_reg;

endmodule

// File: tb/tb_spike_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_spike_pattern_sequencer
//
// Directed bench with a scoreboard: stimulus tasks push expected stream
// vectors and host read results into queues, and a monitor process pops and
// compares whenever the DUT hands over a vector or a read result is due.
// ---------------------------------------------------------------------------
module tb_spike_pattern_sequencer;

  localparam int NS  = 100;
  localparam int TAW = 8;
  localparam int SPB = 32;
  localparam int BAW = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [TAW-1:0]  mem_addr;
  logic [BAW-1:0]  batch_sel;
  logic            mem_wen;
  logic [SPB-1:0]  mem_data_in;
  logic [SPB-1:0]  mem_data_out;
  logic            start;
  logic            stop;
  logic            loop_en;
  logic [TAW-1:0]  last_timestep;
  logic [NS-1:0]   spikes;
  logic            spikes_valid;
  logic            spikes_ready;
  logic [TAW-1:0]  timestep;
  logic            busy;
  logic            done;
  logic            wr_drop;

  spike_pattern_sequencer #(
    .NUM_SPIKES(NS),
    .TIMESTEP_ADDR_WIDTH(TAW),
    .SPIKES_PER_BATCH(SPB),
    .SPIKE_PATTERN_BATCH_ADDR_WIDTH(BAW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_addr(mem_addr),
    .batch_sel(batch_sel),
    .mem_wen(mem_wen),
    .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out),
    .start(start),
    .stop(stop),
    .loop_en(loop_en),
    .last_timestep(last_timestep),
    .spikes(spikes),
    .spikes_valid(spikes_valid),
    .spikes_ready(spikes_ready),
    .timestep(timestep),
    .busy(busy),
    .done(done),
    .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ts;
    logic [NS-1:0] sp;
    int          cyc;
  } exp_t;

  exp_t            sb_q[$];
  logic [SPB-1:0]  rd_exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int drop_cnt = 0;
  int hs_cnt = 0;
  logic rd_tag = 1'b0;
  logic rd_pending = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pattern word for timestep t, batch b.
  function automatic logic [31:0] pat(input int t, input int b);
    logic [7:0]  hi;
    logic [7:0]  mid;
    logic [15:0] lo;
    hi  = 8'(t) ^ 8'h5A;
    mid = 8'(b * 17 + 3);
    lo  = 16'(t * 4099 + b * 257 + 1);
    return {hi, mid, lo};
  endfunction

  // Full 100-bit vector: only the low 4 bits of batch 3 land on neurons.
  function automatic logic [NS-1:0] vec(input int t);
    logic [31:0] w0, w1, w2, w3;
    w0 = pat(t, 0);
    w1 = pat(t, 1);
    w2 = pat(t, 2);
    w3 = pat(t, 3);
    return {w3[3:0], w2, w1, w0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int t, input int b, input logic [31:0] d);
    mem_addr    = TAW'(t);
    batch_sel   = BAW'(b);
    mem_data_in = d;
    mem_wen     = 1'b1;
    $display("write t=%0d batch=%0d data=%08h", t, b, d);
    tick();
    mem_wen = 1'b0;
  endtask

  task automatic host_read(input int t, input int b, input logic [31:0] exp);
    mem_addr  = TAW'(t);
    batch_sel = BAW'(b);
    rd_exp_q.push_back(exp);
    rd_tag = 1'b1;
    tick();
    rd_tag = 1'b0;
  endtask

  task automatic load_t0_t2();
    for (int t = 0; t < 3; t++)
      for (int b = 0; b < 4; b++)
        host_write(t, b, pat(t, b));
  endtask

  task automatic push_vec(input int t, input int c);
    exp_t e;
    e.ts  = t;
    e.sp  = vec(t);
    e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic start_play(input logic lp, input int last);
    loop_en       = lp;
    last_timestep = TAW'(last);
    start         = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base);
    int g;
    g = 0;
    while (done_cnt == base && g < 60) begin
      tick();
      g++;
    end
    check(name, 128'(g < 60), 128'(1));
    repeat (3) tick();
  endtask

  // Cycle counter and read-result pipeline, updated on the active edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      rd_pending = rd_tag && rst_n;
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic          hold_active;
    logic          post_hs;
    logic [NS-1:0] hold_sp;
    logic [TAW-1:0] hold_ts;
    exp_t          e;
    logic [SPB-1:0] r;
    hold_active = 1'b0;
    post_hs     = 1'b0;
    hold_sp     = '0;
    hold_ts     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_active = 1'b0;
        post_hs     = 1'b0;
      end else begin
        if (rd_pending) begin
          if (rd_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: got %08h expected none", mem_data_out);
          end else begin
            r = rd_exp_q.pop_front();
            $display("read data=%08h", mem_data_out);
            check("rd_data", 128'(mem_data_out), 128'(r));
          end
        end
        if (done)    done_cnt++;
        if (wr_drop) drop_cnt++;
        if (post_hs) begin
          check("clear_valid", 128'(spikes_valid), 128'(0));
          check("clear_spikes", 128'(spikes), 128'(0));
        end
        post_hs = 1'b0;
        if (spikes_valid && hold_active) begin
          check("hold_spikes", 128'(spikes), 128'(hold_sp));
          check("hold_ts", 128'(timestep), 128'(hold_ts));
        end
        if (spikes_valid && !spikes_ready) begin
          hold_active = 1'b1;
          hold_sp     = spikes;
          hold_ts     = timestep;
        end else begin
          hold_active = 1'b0;
        end
        if (spikes_valid && spikes_ready) begin
          hs_cnt++;
          post_hs = 1'b1;
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL hs_unexpected: got ts=%0d expected none", timestep);
          end else begin
            e = sb_q.pop_front();
            $display("accept ts=%0d cyc=%0d", timestep, cyc);
            check("spikes", 128'(spikes), 128'(e.sp));
            check("timestep", 128'(timestep), 128'(e.ts));
            if (e.cyc >= 0) check("latency", 128'(cyc), 128'(e.cyc));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int base;
    int dbase;
    int g;

    rst_n         = 1'b0;
    mem_addr      = '0;
    batch_sel     = '0;
    mem_wen       = 1'b0;
    mem_data_in   = '0;
    start         = 1'b0;
    stop          = 1'b0;
    loop_en       = 1'b0;
    last_timestep = '0;
    spikes_ready  = 1'b0;

    // Reset state.
    #12;
    check("rst_spikes", 128'(spikes), 128'(0));
    check("rst_valid", 128'(spikes_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_wr_drop", 128'(wr_drop), 128'(0));
    check("rst_timestep", 128'(timestep), 128'(0));
    check("rst_rd", 128'(mem_data_out), 128'(0));
    #10;
    rst_n = 1'b1;
    tick();

    // 1: full-width writes, padding bits dropped, out-of-range batch.
    for (int b = 0; b < 4; b++) host_write(5, b, 32'hFFFF_FFFF);
    host_read(5, 3, 32'h0000_000F);
    host_read(5, 0, 32'hFFFF_FFFF);
    dbase = drop_cnt;
    host_write(5, 4, 32'h1234_5678);
    check("t1_drop_now", 128'(wr_drop), 128'(1));
    tick();
    check("t1_drop_cnt", 128'(drop_cnt), 128'(dbase + 1));
    host_read(5, 4, 32'h0000_0000);
    // Read-during-write at the same address returns the old contents.
    mem_addr    = 8'd5;
    batch_sel   = 6'd1;
    mem_data_in = 32'h0BAD_F00D;
    mem_wen     = 1'b1;
    rd_exp_q.push_back(32'hFFFF_FFFF);
    rd_tag = 1'b1;
    tick();
    mem_wen = 1'b0;
    rd_tag  = 1'b0;
    host_read(5, 1, 32'h0BAD_F00D);

    // 2: straight playback, ready held high, two cycles per vector.
    load_t0_t2();
    spikes_ready = 1'b1;
    c0 = cyc;
    push_vec(0, c0 + 2);
    push_vec(1, c0 + 4);
    push_vec(2, c0 + 6);
    base = done_cnt;
    start_play(1'b0, 2);
    check("t2_busy", 128'(busy), 128'(1));
    wait_done("t2_done_seen", base);
    check("t2_done_once", 128'(done_cnt), 128'(base + 1));
    check("t2_busy_low", 128'(busy), 128'(0));
    check("t2_sb_empty", 128'(sb_q.size()), 128'(0));

    // 3: back-pressure on timestep 1.
    push_vec(0, -1);
    push_vec(1, -1);
    push_vec(2, -1);
    base = done_cnt;
    start_play(1'b0, 2);
    g = 0;
    while (!(spikes_valid && timestep == 8'd1) && g < 20) begin
      tick();
      g++;
    end
    check("t3_reach_ts1", 128'(g < 20), 128'(1));
    spikes_ready = 1'b0;
    repeat (5) tick();
    spikes_ready = 1'b1;
    wait_done("t3_done_seen", base);
    check("t3_done_once", 128'(done_cnt), 128'(base + 1));
    check("t3_sb_empty", 128'(sb_q.size()), 128'(0));

    // 4: looping 0,1,0,1,0 then stop on the third timestep-0 vector.
    push_vec(0, -1);
    push_vec(1, -1);
    push_vec(0, -1);
    push_vec(1, -1);
    push_vec(0, -1);
    base  = done_cnt;
    c0    = hs_cnt;
    start_play(1'b1, 1);
    g = 0;
    while (!(spikes_valid && timestep == 8'd0 && hs_cnt == c0 + 4) && g < 40) begin
      tick();
      g++;
    end
    check("t4_reach_stop", 128'(g < 40), 128'(1));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t4_busy_low", 128'(busy), 128'(0));
    check("t4_valid_low", 128'(spikes_valid), 128'(0));
    repeat (4) tick();
    check("t4_no_done", 128'(done_cnt), 128'(base));
    check("t4_hs_total", 128'(hs_cnt), 128'(c0 + 5));
    check("t4_sb_empty", 128'(sb_q.size()), 128'(0));

    // 5: host write while busy is dropped and leaves memory intact.
    spikes_ready = 1'b0;
    push_vec(0, -1);
    push_vec(1, -1);
    push_vec(2, -1);
    base  = done_cnt;
    dbase = drop_cnt;
    start_play(1'b0, 2);
    repeat (2) tick();
    host_write(1, 0, 32'hDEAD_BEEF);
    check("t5_drop_now", 128'(wr_drop), 128'(1));
    spikes_ready = 1'b1;
    wait_done("t5_done_seen", base);
    check("t5_drop_cnt", 128'(drop_cnt), 128'(dbase + 1));
    check("t5_sb_empty", 128'(sb_q.size()), 128'(0));
    host_read(1, 0, pat(1, 0));
    // start together with stop in idle.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    repeat (2) tick();
    check("t5_ss_busy", 128'(busy), 128'(0));
    check("t5_ss_valid", 128'(spikes_valid), 128'(0));

    // 6: asynchronous reset while presenting, then replay retained data.
    spikes_ready = 1'b0;
    start_play(1'b0, 2);
    repeat (2) tick();
    check("t6_presenting", 128'(spikes_valid), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 128'(spikes_valid), 128'(0));
    check("t6_rst_spikes", 128'(spikes), 128'(0));
    check("t6_rst_busy", 128'(busy), 128'(0));
    check("t6_rst_ts", 128'(timestep), 128'(0));
    #1;
    rst_n = 1'b1;
    tick();
    spikes_ready = 1'b1;
    push_vec(0, -1);
    push_vec(1, -1);
    push_vec(2, -1);
    base = done_cnt;
    start_play(1'b0, 2);
    wait_done("t6_done_seen", base);
    check("t6_sb_empty", 128'(sb_q.size()), 128'(0));
    host_read(0, 1, pat(0, 1));
    repeat (3) tick();
    check("rd_q_empty", 128'(rd_exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
